// File: rtl/polar_pkg.sv
// Shared types and constants for the polar_seq magnitude/angle sequencer.
package polar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQX,
    S_SQY,
    S_ROOT,
    S_DIV,
    S_DONE
  } state_t;

  localparam int FRAC      = 4;
  localparam int DIV_ITERS = 5;
  localparam int THETA_W   = 7;

  // round(atan(i/16) in degrees), indexed by the 0..16 ratio quotient
  localparam logic [THETA_W-1:0] ATAN_LUT [0:16] = '{
    7'd0,  7'd4,  7'd7,  7'd11, 7'd14, 7'd17, 7'd21, 7'd24, 7'd27,
    7'd29, 7'd32, 7'd35, 7'd37, 7'd39, 7'd41, 7'd43, 7'd45
  };

endpackage

// File: rtl/polar_seq_if.sv
// Operand/result handshake bundle for polar_seq; master drives operands, slave returns results.
interface polar_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_mag;
  logic [6:0]   out_theta;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_mag, out_theta
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_mag, out_theta
  );
endinterface

// File: rtl/polar_isqrt.sv
// Iterative floor square root, two radicand bits per cycle, W+1 cycles per root.
module polar_isqrt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2*W:0] radicand,
  output logic         done,
  output logic [W:0]   root
);
  localparam int ITERS = W + 1;
  localparam int RW    = W + 4;
  localparam int CW    = $clog2(ITERS);

  logic                 run;
  logic [CW-1:0]        cnt;
  logic [2*ITERS-1:0]   rad_sh;
  logic [RW-1:0]        rem;
  logic [2*ITERS-1:0]   rad_src;
  logic [RW-1:0]        rem_src;
  logic [W:0]           root_src;
  logic [RW-1:0]        rem_try;
  logic [RW-1:0]        trial;
  logic                 fits;

  // The first digit is resolved on the start edge itself, straight from the radicand port
  always_comb begin
    rad_src  = run ? rad_sh : {1'b0, radicand};
    rem_src  = run ? rem : '0;
    root_src = run ? root : '0;
    rem_try  = {rem_src[RW-3:0], rad_src[2*ITERS-1 -: 2]};
    trial    = {1'b0, root_src, 2'b01};
    fits     = (rem_try >= trial);
    done     = run && (cnt == CW'(ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      rad_sh <= '0;
      rem    <= '0;
      root   <= '0;
    end else if (run || start) begin
      rad_sh <= rad_src << 2;
      rem    <= fits ? (rem_try - trial) : rem_try;
      root   <= {root_src[W-1:0], fits};
      if (!run) begin
        run <= 1'b1;
        cnt <= CW'(1);
      end else if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/polar_seq.sv
// Cartesian-to-polar sequencer: shared squarer, iterative sqrt, optional ratio divide + atan LUT.
// Angle path is built only when POLAR_ANGLE_EN is defined; otherwise out_theta is tied to 0.
module polar_seq
  import polar_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  polar_seq_if.slave bus,
  output logic       busy
);
  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   x_reg;
  logic [W-1:0]   y_reg;
  logic [W-1:0]   sq_op;
  logic [2*W-1:0] product;
  logic [2*W:0]   acc;
  logic           sqrt_start;
  logic           sqrt_done;
  logic [W:0]     sqrt_root;

`ifdef POLAR_ANGLE_EN
  logic           x_ge_y;
  logic           large_zero;
  logic           q_fit;
  logic           div_bit;
  logic [W-1:0]   small_op;
  logic [W-1:0]   large_op;
  logic [W:0]     div_rem;
  logic [W:0]     rem_shift;
  logic [FRAC:0]  div_q;
  logic [FRAC:0]  q_next;
  logic [FRAC:0]  q_sel;
  logic [2:0]     div_cnt;
  logic [6:0]     lut_deg;
  logic [6:0]     theta_next;
  logic [6:0]     theta_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
    sqrt_start    = (state_q == S_ROOT);
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_SQX;
      S_SQX:  state_d = S_SQY;
      S_SQY:  state_d = S_ROOT;
      S_ROOT: begin
        if (sqrt_done) begin
`ifdef POLAR_ANGLE_EN
          state_d = S_DIV;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DIV: begin
`ifdef POLAR_ANGLE_EN
        if (div_cnt == 3'(DIV_ITERS - 1)) state_d = S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One squarer shared over two cycles: x² in SQX, then y² accumulated in SQY
  always_comb begin
    sq_op   = (state_q == S_SQY) ? y_reg : x_reg;
    product = {{W{1'b0}}, sq_op} * {{W{1'b0}}, sq_op};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
      acc   <= '0;
    end else begin
      if (state_q == S_IDLE && bus.in_valid) begin
        x_reg <= bus.in_x;
        y_reg <= bus.in_y;
      end
      if (state_q == S_SQX) acc <= {1'b0, product};
      if (state_q == S_SQY) acc <= acc + {1'b0, product};
    end
  end

  polar_isqrt #(.W(W)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (sqrt_start),
    .radicand (acc),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  assign bus.out_mag = sqrt_root;

`ifdef POLAR_ANGLE_EN
  // Dividend is small<<FRAC; seeding the remainder with small>>1 leaves small[0] as the only nonzero bit to shift in
  always_comb begin
    x_ge_y     = (x_reg >= y_reg);
    small_op   = x_ge_y ? y_reg : x_reg;
    large_op   = x_ge_y ? x_reg : y_reg;
    large_zero = (large_op == '0);
    div_bit    = (div_cnt == 3'd0) ? small_op[0] : 1'b0;
    rem_shift  = {div_rem[W-1:0], div_bit};
    q_fit      = (rem_shift >= {1'b0, large_op});
    q_next     = {div_q[FRAC-1:0], q_fit};
    q_sel      = large_zero ? '0 : q_next;
    lut_deg    = ATAN_LUT[q_sel];
    theta_next = x_ge_y ? lut_deg : (7'd90 - lut_deg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_rem <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      theta_q <= '0;
    end else if (state_q == S_ROOT && sqrt_done) begin
      div_rem <= {2'b00, small_op[W-1:1]};
      div_q   <= '0;
      div_cnt <= '0;
    end else if (state_q == S_DIV) begin
      div_cnt <= div_cnt + 3'd1;
      if (!large_zero) begin
        div_rem <= q_fit ? (rem_shift - {1'b0, large_op}) : rem_shift;
        div_q   <= q_next;
      end
      if (div_cnt == 3'(DIV_ITERS - 1)) theta_q <= theta_next;
    end
  end

  assign bus.out_theta = theta_q;
`else
  assign bus.out_theta = '0;
`endif

endmodule

// File: tb/tb_polar_seq.sv
// Scoreboard bench for polar_seq: driver pushes model results, monitor pops on each out_valid rise.
module tb_polar_seq;

  localparam int W = 8;
`ifdef POLAR_ANGLE_EN
  localparam int LATENCY = W + 8;
`else
  localparam int LATENCY = W + 3;
`endif

  typedef struct {
    int mag;
    int theta;
    int accept_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;
  int   hold_cycles = 0;
  exp_t exp_q[$];
  int   atan_tab [17] = '{0, 4, 7, 11, 14, 17, 21, 24, 27, 29, 32, 35, 37, 39, 41, 43, 45};

  polar_seq_if #(.W(W)) bus ();

  polar_seq #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int model_mag(input int x, input int y);
    int s = x * x + y * y;
    int m = 0;
    while ((m + 1) * (m + 1) <= s) m++;
    return m;
  endfunction

  function automatic int model_theta(input int x, input int y);
`ifdef POLAR_ANGLE_EN
    int small = (x < y) ? x : y;
    int large = (x < y) ? y : x;
    int q;
    if (large == 0) return 0;
    q = (small * 16) / large;
    return (x >= y) ? atan_tab[q] : 90 - atan_tab[q];
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input int x, input int y);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_x     = W'(x);
    bus.in_y     = W'(y);
    e.mag         = model_mag(x, y);
    e.theta       = model_theta(x, y);
    e.accept_edge = edge_cnt + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x     = W'($urandom);
    bus.in_y     = W'($urandom);
    checkOutput("busy_after_accept", int'(busy), 1);
    checkOutput("in_ready_after_accept", int'(bus.in_ready), 0);
  endtask

  // Monitor: samples 2 time units after each rising edge and owns out_ready
  initial begin : monitor
    exp_t cur;
    logic holding = 1'b0;
    logic consume_next = 1'b0;
    int   held_mag = 0;
    int   held_theta = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        holding      = 1'b0;
        consume_next = 1'b0;
        continue;
      end
      if (consume_next) begin
        checkOutput("release_out_valid", int'(bus.out_valid), 0);
        checkOutput("release_in_ready", int'(bus.in_ready), 1);
        holding      = 1'b0;
        consume_next = 1'b0;
      end
      if (bus.out_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            checkOutput("latency", edge_cnt - cur.accept_edge, LATENCY);
            checkOutput("mag", int'(bus.out_mag), cur.mag);
            checkOutput("theta", int'(bus.out_theta), cur.theta);
          end
          held_mag   = int'(bus.out_mag);
          held_theta = int'(bus.out_theta);
          holding    = 1'b1;
        end else begin
          checkOutput("held_mag", int'(bus.out_mag), held_mag);
          checkOutput("held_theta", int'(bus.out_theta), held_theta);
        end
        checkOutput("in_ready_in_done", int'(bus.in_ready), 0);
        if (hold_cycles > 0) begin
          bus.out_ready = 1'b0;
          hold_cycles--;
        end else begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        consume_next = bus.out_ready;
      end else begin
        bus.out_ready = $urandom_range(0, 1) != 0;
      end
    end
  end

  initial begin : main
    int x;
    int y;
    int xs[5] = '{3, 255, 200, 0, 0};
    int ys[5] = '{4, 255, 0, 0, 200};
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", int'(bus.out_valid), 0);
    checkOutput("reset_in_ready", int'(bus.in_ready), 1);
    checkOutput("reset_out_mag", int'(bus.out_mag), 0);
    checkOutput("reset_out_theta", int'(bus.out_theta), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(xs[i], ys[i]);

    // Backpressure in DONE plus ignored in_valid pulses while the root is iterating
    applyStimulus(9, 40);
    hold_cycles = 5;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = W'($urandom);
      bus.in_y     = W'($urandom);
      @(negedge clk);
      checkOutput("busy_during_root", int'(busy), 1);
    end
    bus.in_valid = 1'b0;

    // Reset in the middle of ROOT abandons the job
    applyStimulus(100, 50);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
    checkOutput("midrst_in_ready", int'(bus.in_ready), 1);
    checkOutput("midrst_out_mag", int'(bus.out_mag), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    applyStimulus(6, 8);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 9))
        0:       x = 0;
        1:       x = 255;
        default: x = int'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 9))
        0:       y = 0;
        1:       y = 255;
        default: y = int'($urandom_range(0, 255));
      endcase
      applyStimulus(x, y);
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("drain_pending", exp_q.size(), 0);
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
